// File: rtl/bcm_readout_sequencer_if.sv
// bcm_readout_sequencer_if: readout stream handshake.
// Signals: tdata (32b word), tvalid, tready, tlast.
// Modports: master (sequencer drives data), slave (consumer drives tready).
interface bcm_readout_sequencer_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/bcm_readout_sequencer.sv
// bcm_readout_sequencer: arms an acquisition, waits for it to finish, then reads every sample out as a stream.
// Ports: sysClk/sysReset_n (async active-low); start, acqCount, passCount (request);
//        sysCsrStrobe, sysAddrStrobe, GPIO_OUT, sysStatusReg, sysReadoutReg (acquisition block);
//        m (stream master modport); busy, done, timeout (status).
// Optional: define BCM_SEQ_TIMEOUT_EN to add a WAIT_DONE watchdog (TIMEOUT_CYCLES) and the sticky timeout flag.
module bcm_readout_sequencer #(
    parameter int CHANNEL_COUNT         = 4,
    parameter int AXI_SAMPLES_PER_CLOCK = 2,
    parameter int DPRAM_ADDRESS_WIDTH   = 10,
    parameter int PASS_COUNT_WIDTH      = 5,
    parameter int SETTLE_CYCLES         = 8
`ifdef BCM_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 125000000
`endif
) (
    input  logic                           sysClk,
    input  logic                           sysReset_n,
    input  logic                           start,
    input  logic [DPRAM_ADDRESS_WIDTH-1:0] acqCount,
    input  logic [PASS_COUNT_WIDTH-1:0]    passCount,
    output logic                           sysCsrStrobe,
    output logic                           sysAddrStrobe,
    output logic [31:0]                    GPIO_OUT,
    input  logic [31:0]                    sysStatusReg,
    input  logic [31:0]                    sysReadoutReg,
    bcm_readout_sequencer_if.master        m,
    output logic                           busy,
    output logic                           done,
    output logic                           timeout
);
    localparam int AW = DPRAM_ADDRESS_WIDTH;
    localparam int CW = CHANNEL_COUNT > 1 ? $clog2(CHANNEL_COUNT) : 1;
    localparam int SW = AXI_SAMPLES_PER_CLOCK > 1 ? $clog2(AXI_SAMPLES_PER_CLOCK) : 1;
    localparam int SB = $clog2(AXI_SAMPLES_PER_CLOCK);

    typedef enum logic [2:0] {IDLE, ARM, WAIT_ACTIVE, WAIT_DONE, ADDR, SETTLE, PUSH, FINISH} state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           acq_q, acq_d, addr_q, addr_d;
    logic [PASS_COUNT_WIDTH-1:0] pass_q, pass_d;
    logic [CW-1:0]           ch_q, ch_d;
    logic [SW-1:0]           smp_q, smp_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [31:0]             tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic                    is_last;
    logic                    unused_status;
`ifdef BCM_SEQ_TIMEOUT_EN
    logic                    timeout_q, timeout_d;
`endif

    assign unused_status = ^sysStatusReg[30:0];
    assign is_last = addr_q == acq_q && ch_q == CW'(CHANNEL_COUNT - 1) && smp_q == SW'(AXI_SAMPLES_PER_CLOCK - 1);
    // One counter serves WAIT_ACTIVE, SETTLE and the watchdog: it restarts on every state change.
    assign cnt_d = (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;

    always_comb begin
        state_d       = state_q;
        acq_d         = acq_q;
        pass_d        = pass_q;
        addr_d        = addr_q;
        ch_d          = ch_q;
        smp_d         = smp_q;
        tdata_d       = tdata_q;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        sysCsrStrobe  = 1'b0;
        sysAddrStrobe = 1'b0;
        GPIO_OUT      = 32'd0;
`ifdef BCM_SEQ_TIMEOUT_EN
        timeout_d     = timeout_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                acq_d   = acqCount;
                pass_d  = passCount;
                addr_d  = '0;
                ch_d    = '0;
                smp_d   = '0;
                state_d = ARM;
`ifdef BCM_SEQ_TIMEOUT_EN
                timeout_d = 1'b0;
`endif
            end
            ARM: begin
                sysCsrStrobe = 1'b1;
                GPIO_OUT     = 32'h8000_0000 | (32'(pass_q) << AW) | 32'(acq_q);
                state_d      = WAIT_ACTIVE;
            end
            WAIT_ACTIVE: if (sysStatusReg[31] || cnt_q == 32'd3) state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (!sysStatusReg[31]) state_d = ADDR;
`ifdef BCM_SEQ_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_CYCLES - 1) begin
                    // Disarm the acquisition block and abandon the readout.
                    sysCsrStrobe = 1'b1;
                    timeout_d    = 1'b1;
                    state_d      = FINISH;
                end
`endif
            end
            ADDR: begin
                sysAddrStrobe = 1'b1;
                GPIO_OUT      = (32'(ch_q) << 24) | (32'(addr_q) << SB) | 32'(smp_q);
                state_d       = SETTLE;
            end
            SETTLE: if (cnt_q == 32'(SETTLE_CYCLES - 1)) begin
                tdata_d  = sysReadoutReg;
                tvalid_d = 1'b1;
                tlast_d  = is_last;
                state_d  = PUSH;
            end
            PUSH: if (m.tready) begin
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                state_d  = is_last ? FINISH : ADDR;
                if (smp_q == SW'(AXI_SAMPLES_PER_CLOCK - 1)) begin
                    smp_d = '0;
                    if (ch_q == CW'(CHANNEL_COUNT - 1)) begin
                        ch_d   = '0;
                        addr_d = addr_q + 1'b1;
                    end else ch_d = ch_q + 1'b1;
                end else smp_d = smp_q + 1'b1;
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            state_q  <= IDLE;
            acq_q    <= '0;
            pass_q   <= '0;
            addr_q   <= '0;
            ch_q     <= '0;
            smp_q    <= '0;
            cnt_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
`ifdef BCM_SEQ_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            acq_q    <= acq_d;
            pass_q   <= pass_d;
            addr_q   <= addr_d;
            ch_q     <= ch_d;
            smp_q    <= smp_d;
            cnt_q    <= cnt_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
`ifdef BCM_SEQ_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    assign m.tdata  = tdata_q;
    assign m.tvalid = tvalid_q;
    assign m.tlast  = tlast_q;
    assign busy     = state_q != IDLE;
    assign done     = state_q == FINISH;
`ifdef BCM_SEQ_TIMEOUT_EN
    assign timeout  = timeout_q;
`else
    assign timeout  = 1'b0;
`endif
endmodule

// File: tb/tb_bcm_readout_sequencer.sv
// tb_bcm_readout_sequencer: randomized self-checking bench for bcm_readout_sequencer.
module tb_bcm_readout_sequencer;
    localparam int CH = 2;
    localparam int SPC = 2;

    logic        sysClk = 1'b0;
    logic        sysReset_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  acqCount = '0;
    logic [4:0]  passCount = '0;
    logic [31:0] sysStatusReg = '0;
    logic [31:0] sysReadoutReg = '0;
    logic        sysCsrStrobe, sysAddrStrobe, busy, done, timeout;
    logic [31:0] GPIO_OUT;
    int          checks = 0;
    int          passes = 0;

    bcm_readout_sequencer_if bif();

    bcm_readout_sequencer #(
        .CHANNEL_COUNT(CH), .AXI_SAMPLES_PER_CLOCK(SPC), .DPRAM_ADDRESS_WIDTH(10),
        .PASS_COUNT_WIDTH(5), .SETTLE_CYCLES(3)
`ifdef BCM_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .sysClk(sysClk), .sysReset_n(sysReset_n), .start(start), .acqCount(acqCount),
        .passCount(passCount), .sysCsrStrobe(sysCsrStrobe), .sysAddrStrobe(sysAddrStrobe),
        .GPIO_OUT(GPIO_OUT), .sysStatusReg(sysStatusReg), .sysReadoutReg(sysReadoutReg),
        .m(bif), .busy(busy), .done(done), .timeout(timeout)
    );

    always #5 sysClk = ~sysClk;

    // Runs one sequence from a negedge. The bench plays the acquisition block: status bit 31 rises
    // with the arm strobe for active_len cycles, and each address strobe loads readout = GPIO ^ salt.
    // abort_after > 0 returns early, stalled, with word abort_after+1 presented.
    task automatic run_seq(input int acq, input int pass, input int rmode, input int active_len,
                           input bit inject, input int abort_after, input bit exp_to);
        logic [31:0] salt, hd, exp_arm;
        logic        hl;
        bit          hold, seen;
        int          c0, cd, st_left, viol, stall_v, n;
        logic [31:0] got_d[$], got_a[$], csr_g[$], exp_a[$];
        logic        got_l[$];
        salt = $urandom; hold = 0; seen = 0; c0 = 0; cd = 0; st_left = 0; viol = 0; stall_v = 0;
        hd = '0; hl = 1'b0;
        acqCount = 10'(acq); passCount = 5'(pass); start = 1'b1;
        @(negedge sysClk);
        start = 1'b0;
        checks++;
        if (sysCsrStrobe !== 1'b1) $display("FAIL start_accept: sysCsrStrobe=%b expected 1", sysCsrStrobe);
        else passes++;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            start = 1'b0;
            if (sysCsrStrobe === 1'b1) begin
                csr_g.push_back(GPIO_OUT);
                if (csr_g.size() == 1) begin c0 = cyc; st_left = active_len; end
            end
            if (sysAddrStrobe === 1'b1) begin
                got_a.push_back(GPIO_OUT);
                sysReadoutReg = GPIO_OUT ^ salt;
            end
            if (sysCsrStrobe === 1'b1 && sysAddrStrobe === 1'b1) viol++;
            if (sysCsrStrobe !== 1'b1 && sysAddrStrobe !== 1'b1 && GPIO_OUT !== 32'd0) viol++;
            if (hold && (bif.tvalid !== 1'b1 || bif.tdata !== hd || bif.tlast !== hl)) stall_v++;
            if (done === 1'b1) begin seen = 1; cd = cyc; break; end
            sysStatusReg = {st_left > 0, 31'd0};
            if (st_left > 0) st_left--;
            bif.tready = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
            if (abort_after > 0 && got_d.size() == abort_after && bif.tvalid === 1'b1) begin
                bif.tready = 1'b0;
                sysStatusReg = '0;
                return;
            end
            if (inject && busy === 1'b1 && $urandom_range(0, 5) == 0) start = 1'b1;
            if (bif.tvalid === 1'b1 && bif.tready) begin
                got_d.push_back(bif.tdata);
                got_l.push_back(bif.tlast);
            end
            hold = bif.tvalid === 1'b1 && !bif.tready;
            hd = bif.tdata; hl = bif.tlast;
            @(negedge sysClk);
        end
        start = 1'b0; sysStatusReg = '0; bif.tready = 1'b0;
        for (int a = 0; a <= acq; a++)
            for (int c = 0; c < CH; c++)
                for (int s = 0; s < SPC; s++)
                    exp_a.push_back((32'(c) << 24) | (32'(a) << 1) | 32'(s));
        exp_arm = 32'h8000_0000 | (32'(pass) << 10) | 32'(acq);
        checks++;
        if (!seen) $display("FAIL done_seen: no done within cycle budget");
        else passes++;
        if (exp_to) begin
            checks++;
            if (got_d.size() != 0) $display("FAIL to_words: got %0d words expected 0", got_d.size());
            else passes++;
            checks++;
            if (csr_g.size() != 2) $display("FAIL to_csr_count: got %0d strobes expected 2", csr_g.size());
            else passes++;
            if (csr_g.size() >= 2) begin
                checks++;
                if (csr_g[1] !== 32'd0) $display("FAIL to_csr_gpio: got %h expected 0", csr_g[1]);
                else passes++;
            end
            checks++;
            if (timeout !== 1'b1) $display("FAIL to_flag: timeout=%b expected 1", timeout);
            else passes++;
            checks++;
            if (cd - c0 != 102) $display("FAIL to_latency: done %0d cycles after arm, expected 102", cd - c0);
            else passes++;
        end else begin
            n = exp_a.size();
            checks++;
            if (csr_g.size() != 1) $display("FAIL csr_count: got %0d expected 1", csr_g.size());
            else passes++;
            if (csr_g.size() >= 1) begin
                checks++;
                if (csr_g[0] !== exp_arm) $display("FAIL arm_gpio: got %h expected %h", csr_g[0], exp_arm);
                else passes++;
            end
            checks++;
            if (got_d.size() != n) $display("FAIL word_count: got %0d expected %0d", got_d.size(), n);
            else passes++;
            checks++;
            if (got_a.size() != n) $display("FAIL addr_count: got %0d expected %0d", got_a.size(), n);
            else passes++;
            for (int i = 0; i < n && i < got_a.size(); i++) begin
                checks++;
                if (got_a[i] !== exp_a[i]) $display("FAIL addr_gpio[%0d]: got %h expected %h", i, got_a[i], exp_a[i]);
                else passes++;
            end
            for (int i = 0; i < n && i < got_d.size(); i++) begin
                checks++;
                if (got_d[i] !== (exp_a[i] ^ salt)) $display("FAIL tdata[%0d]: got %h expected %h", i, got_d[i], exp_a[i] ^ salt);
                else passes++;
                checks++;
                if (got_l[i] !== (i == n - 1)) $display("FAIL tlast[%0d]: got %b expected %b", i, got_l[i], i == n - 1);
                else passes++;
            end
            checks++;
            if (timeout !== 1'b0) $display("FAIL timeout_idle: got %b expected 0", timeout);
            else passes++;
        end
        checks++;
        if (viol != 0) $display("FAIL strobe_gpio: %0d violation cycles expected 0", viol);
        else passes++;
        checks++;
        if (stall_v != 0) $display("FAIL stall_stable: %0d unstable cycles expected 0", stall_v);
        else passes++;
        @(negedge sysClk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sysCsrStrobe !== 1'b0)
            $display("FAIL after_done: done=%b busy=%b csr=%b expected 0 0 0", done, busy, sysCsrStrobe);
        else passes++;
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if ({sysCsrStrobe, sysAddrStrobe, bif.tvalid, bif.tlast, busy, done, timeout} !== 7'd0 ||
            GPIO_OUT !== 32'd0 || bif.tdata !== 32'd0)
            $display("FAIL %s: csr=%b addr=%b gpio=%h tdata=%h tvalid=%b tlast=%b busy=%b done=%b timeout=%b expected all 0",
                     tag, sysCsrStrobe, sysAddrStrobe, GPIO_OUT, bif.tdata, bif.tvalid, bif.tlast, busy, done, timeout);
        else passes++;
    endtask

    task automatic test_reset;
        sysReset_n = 1'b0; bif.tready = 1'b0;
        repeat (3) @(negedge sysClk);
        check_zero("reset_outputs");
        sysReset_n = 1'b1;
        @(negedge sysClk);
        check_zero("idle_after_reset");
    endtask

    task automatic test_basic;
        run_seq(3, 1, 0, 20, 0, 0, 0);
    endtask

    task automatic test_stall;
        run_seq(3, 1, 1, 20, 0, 0, 0);
    endtask

    task automatic test_single_addr;
        run_seq(0, int'($urandom_range(0, 31)), 2, 5, 0, 0, 0);
    endtask

    task automatic test_no_active;
        run_seq(2, 7, 0, 0, 0, 0, 0);
    endtask

    task automatic test_busy_start;
        run_seq(3, 2, 2, 10, 1, 0, 0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 4; k++)
            run_seq(int'($urandom_range(0, 7)), int'($urandom_range(0, 31)), 2,
                    int'($urandom_range(0, 30)), 1'($urandom_range(0, 1)), 0, 0);
    endtask

    task automatic test_reset_mid;
        run_seq(3, 1, 0, 20, 0, 4, 0);
        checks++;
        if (bif.tvalid !== 1'b1) $display("FAIL mid_push: tvalid=%b expected 1", bif.tvalid);
        else passes++;
        #2 sysReset_n = 1'b0;
        #1 check_zero("async_reset_mid");
        @(negedge sysClk);
        sysReset_n = 1'b1;
        run_seq(3, 1, 0, 20, 0, 0, 0);
    endtask

`ifdef BCM_SEQ_TIMEOUT_EN
    task automatic test_timeout;
        run_seq(2, 3, 0, 1000000, 0, 0, 1);
        run_seq(1, 4, 0, 10, 0, 0, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_single_addr();
        test_no_active();
        test_busy_start();
        test_random();
        test_reset_mid();
`ifdef BCM_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
